// File: rtl/load_use_scoreboard_if.sv
// Operand-delivery bundle between the ID stage and the load-use scoreboard.
// The master drives the ID and MEM stage signals; the scoreboard (slave) returns the stall and issue controls.
interface load_use_scoreboard_if #(
  parameter int unsigned WIDTH_SOURCE = 5,
  parameter int unsigned CNT_WIDTH    = 16
);
  localparam int unsigned NUM_REGS = 1 << WIDTH_SOURCE;

  logic                    ID_Valid;
  logic [WIDTH_SOURCE-1:0] ID_rs1;
  logic [WIDTH_SOURCE-1:0] ID_rs2;
  logic                    ID_rs1_Used;
  logic                    ID_rs2_Used;
  logic [WIDTH_SOURCE-1:0] ID_rd;
  logic                    ID_Reg_Wr;
  logic                    ID_Mem_Rd;
  logic                    Flush;
  logic                    MEM_Load_Done;
  logic [WIDTH_SOURCE-1:0] MEM_rd;
  logic                    Drain_Req;
  logic                    ID_Issue;
  logic                    Stall;
  logic                    Drain_Done;
  logic [NUM_REGS-1:0]     Busy_Vec;
  logic [CNT_WIDTH-1:0]    Stall_Cnt;

  modport master (
    output ID_Valid, ID_rs1, ID_rs2, ID_rs1_Used, ID_rs2_Used, ID_rd,
           ID_Reg_Wr, ID_Mem_Rd, Flush, MEM_Load_Done, MEM_rd, Drain_Req,
    input  ID_Issue, Stall, Drain_Done, Busy_Vec, Stall_Cnt
  );

  modport slave (
    input  ID_Valid, ID_rs1, ID_rs2, ID_rs1_Used, ID_rs2_Used, ID_rd,
           ID_Reg_Wr, ID_Mem_Rd, Flush, MEM_Load_Done, MEM_rd, Drain_Req,
    output ID_Issue, Stall, Drain_Done, Busy_Vec, Stall_Cnt
  );
endinterface

// File: rtl/load_use_scoreboard.sv
// Load-use scoreboard: tracks in-flight load destinations and stalls dependent instructions in ID.
// It also offers a drain handshake that empties all outstanding loads before FENCE/ECALL.
module load_use_scoreboard #(
  parameter int unsigned WIDTH_SOURCE = 5,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input logic                   CLK,
  input logic                   RST,
  load_use_scoreboard_if.slave  bus
);
  localparam int unsigned NUM_REGS = 1 << WIDTH_SOURCE;

  typedef enum logic [1:0] {RUN, STALL, DRAIN} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [NUM_REGS-1:0]  busy;
  logic [NUM_REGS-1:0]  clr_mask;
  logic [NUM_REGS-1:0]  set_mask;
  logic [NUM_REGS-1:0]  eff_busy;
  logic                 hazard;
  logic                 stall;
  logic                 issue;
  logic                 drain_done;
  logic                 drain_done_nxt;
  logic [CNT_WIDTH-1:0] stall_cnt;

  // A completing load is forwardable next cycle, so its bit is bypassed now; x0 is never busy.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (bus.MEM_Load_Done) clr_mask = NUM_REGS'(1) << bus.MEM_rd;
    eff_busy    = busy & ~clr_mask;
    eff_busy[0] = 1'b0;
    hazard = bus.ID_Valid & ((bus.ID_rs1_Used & eff_busy[bus.ID_rs1]) |
                             (bus.ID_rs2_Used & eff_busy[bus.ID_rs2]));
    stall  = hazard | (state == DRAIN);
    issue  = bus.ID_Valid & ~stall & ~bus.Flush;
    if (issue && bus.ID_Mem_Rd && bus.ID_Reg_Wr && (bus.ID_rd != '0))
      set_mask = NUM_REGS'(1) << bus.ID_rd;
  end

  // Drain takes priority over hazard stalls and exits only once nothing is outstanding.
  always_comb begin
    state_nxt      = state;
    drain_done_nxt = 1'b0;
    case (state)
      RUN: begin
        if (bus.Drain_Req)  state_nxt = DRAIN;
        else if (hazard)    state_nxt = STALL;
      end
      STALL: begin
        if (bus.Drain_Req)  state_nxt = DRAIN;
        else if (!hazard)   state_nxt = RUN;
      end
      DRAIN: begin
        if (eff_busy == '0) begin
          state_nxt      = RUN;
          drain_done_nxt = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Set is ORed after the clear so a newer load keeps ownership of the register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= RUN;
      busy       <= '0;
      drain_done <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      busy       <= eff_busy | set_mask;
      drain_done <= drain_done_nxt;
      if (hazard && !bus.Flush && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
    end
  end

  assign bus.ID_Issue   = issue;
  assign bus.Stall      = stall;
  assign bus.Drain_Done = drain_done;
  assign bus.Busy_Vec   = busy;
  assign bus.Stall_Cnt  = stall_cnt;
endmodule

// File: tb/tb_load_use_scoreboard.sv
// Self-checking bench for load_use_scoreboard: directed scenarios plus randomized traffic
// checked against a set-of-outstanding-loads reference model.
module tb_load_use_scoreboard;
  logic CLK;
  logic RST;

  load_use_scoreboard_if #(.WIDTH_SOURCE(5), .CNT_WIDTH(16)) bus ();

  load_use_scoreboard #(.WIDTH_SOURCE(5), .CNT_WIDTH(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks;
  int n_fail;

  // Reference model: which registers await load data, drain in progress, pending pulse, stall count.
  bit        m_busy [32];
  bit        m_draining;
  bit        m_done;
  int        m_cnt;

  function automatic logic [31:0] m_busy_word();
    logic [31:0] w;
    for (int i = 0; i < 32; i++) w[i] = m_busy[i];
    return w;
  endfunction

  task automatic model_comb(output bit st, output bit iss, output bit haz, output bit empty);
    bit waiting [32];
    for (int i = 0; i < 32; i++) waiting[i] = m_busy[i];
    if (bus.MEM_Load_Done) waiting[bus.MEM_rd] = 1'b0;
    waiting[0] = 1'b0;
    haz = bus.ID_Valid && ((bus.ID_rs1_Used && waiting[bus.ID_rs1]) ||
                           (bus.ID_rs2_Used && waiting[bus.ID_rs2]));
    st  = haz || m_draining;
    iss = bus.ID_Valid && !st && !bus.Flush;
    empty = 1'b1;
    for (int i = 0; i < 32; i++) if (waiting[i]) empty = 1'b0;
  endtask

  // Apply one clock edge to the model using the inputs currently driven, then step the DUT.
  task automatic advance();
    bit st, iss, haz, empty;
    model_comb(st, iss, haz, empty);
    if (RST) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      m_draining = 1'b0;
      m_done     = 1'b0;
      m_cnt      = 0;
    end else begin
      m_done = 1'b0;
      if (m_draining) begin
        if (empty) begin
          m_draining = 1'b0;
          m_done     = 1'b1;
        end
      end else if (bus.Drain_Req) begin
        m_draining = 1'b1;
      end
      if (haz && !bus.Flush && m_cnt < 65535) m_cnt++;
      if (bus.MEM_Load_Done) m_busy[bus.MEM_rd] = 1'b0;
      if (iss && bus.ID_Mem_Rd && bus.ID_Reg_Wr && bus.ID_rd != 0) m_busy[bus.ID_rd] = 1'b1;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.ID_Valid      = 1'b0;
    bus.ID_rs1        = '0;
    bus.ID_rs2        = '0;
    bus.ID_rs1_Used   = 1'b0;
    bus.ID_rs2_Used   = 1'b0;
    bus.ID_rd         = '0;
    bus.ID_Reg_Wr     = 1'b0;
    bus.ID_Mem_Rd     = 1'b0;
    bus.Flush         = 1'b0;
    bus.MEM_Load_Done = 1'b0;
    bus.MEM_rd        = '0;
    bus.Drain_Req     = 1'b0;
  endtask

  task automatic drive_load(input int rd);
    idle();
    bus.ID_Valid  = 1'b1;
    bus.ID_rd     = 5'(rd);
    bus.ID_Reg_Wr = 1'b1;
    bus.ID_Mem_Rd = 1'b1;
  endtask

  task automatic drive_alu(input int rs1, input int rs2, input int rd);
    idle();
    bus.ID_Valid    = 1'b1;
    bus.ID_rs1      = 5'(rs1);
    bus.ID_rs2      = 5'(rs2);
    bus.ID_rs1_Used = 1'b1;
    bus.ID_rs2_Used = 1'b1;
    bus.ID_rd       = 5'(rd);
    bus.ID_Reg_Wr   = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    RST = 1'b1;
    advance();
    advance();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    bus.ID_Valid = 1'b1;
    #2;
    n_checks += 5;
    if (bus.Busy_Vec !== 32'h0) begin n_fail++; $display("FAIL reset_busy got %h want 0", bus.Busy_Vec); end
    if (bus.Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", bus.Stall); end
    if (bus.Stall_Cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt got %h want 0", bus.Stall_Cnt); end
    if (bus.Drain_Done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.Drain_Done); end
    if (bus.ID_Issue !== 1'b1) begin n_fail++; $display("FAIL reset_issue got %b want 1", bus.ID_Issue); end
    idle();
    advance();
  endtask

  task automatic test_load_use();
    int cnt0;
    cnt0 = m_cnt;
    drive_load(5); #2;
    n_checks++;
    if (bus.ID_Issue !== 1'b1) begin n_fail++; $display("FAIL lu_c0_issue got %b want 1", bus.ID_Issue); end
    advance();
    drive_alu(5, 1, 6); #2;
    n_checks += 3;
    if (bus.Stall !== 1'b1) begin n_fail++; $display("FAIL lu_c1_stall got %b want 1", bus.Stall); end
    if (bus.ID_Issue !== 1'b0) begin n_fail++; $display("FAIL lu_c1_issue got %b want 0", bus.ID_Issue); end
    if (bus.Busy_Vec[5] !== 1'b1) begin n_fail++; $display("FAIL lu_c1_busy5 got %b want 1", bus.Busy_Vec[5]); end
    advance();
    bus.MEM_Load_Done = 1'b1;
    bus.MEM_rd        = 5'd5; #2;
    n_checks += 2;
    if (bus.Stall !== 1'b0) begin n_fail++; $display("FAIL lu_c2_stall got %b want 0", bus.Stall); end
    if (bus.ID_Issue !== 1'b1) begin n_fail++; $display("FAIL lu_c2_issue got %b want 1", bus.ID_Issue); end
    advance();
    idle(); #2;
    n_checks += 2;
    if (bus.Busy_Vec[5] !== 1'b0) begin n_fail++; $display("FAIL lu_c3_busy5 got %b want 0", bus.Busy_Vec[5]); end
    if (bus.Stall_Cnt !== 16'(cnt0 + 1)) begin n_fail++; $display("FAIL lu_cnt got %0d want %0d", bus.Stall_Cnt, cnt0 + 1); end
    advance();
  endtask

  task automatic test_x0();
    drive_load(0); #2;
    advance();
    drive_alu(0, 0, 6); #2;
    n_checks += 3;
    if (bus.Busy_Vec !== 32'h0) begin n_fail++; $display("FAIL x0_busy got %h want 0", bus.Busy_Vec); end
    if (bus.Stall !== 1'b0) begin n_fail++; $display("FAIL x0_stall got %b want 0", bus.Stall); end
    if (bus.ID_Issue !== 1'b1) begin n_fail++; $display("FAIL x0_issue got %b want 1", bus.ID_Issue); end
    advance();
    idle();
    advance();
  endtask

  task automatic test_back_to_back();
    drive_load(7); advance();
    idle(); advance();
    drive_load(7);
    bus.MEM_Load_Done = 1'b1;
    bus.MEM_rd        = 5'd7; #2;
    n_checks++;
    if (bus.ID_Issue !== 1'b1) begin n_fail++; $display("FAIL b2b_issue2 got %b want 1", bus.ID_Issue); end
    advance();
    drive_alu(7, 2, 8); #2;
    n_checks += 2;
    if (bus.Busy_Vec[7] !== 1'b1) begin n_fail++; $display("FAIL b2b_busy7 got %b want 1", bus.Busy_Vec[7]); end
    if (bus.Stall !== 1'b1) begin n_fail++; $display("FAIL b2b_stall got %b want 1", bus.Stall); end
    advance();
    bus.MEM_Load_Done = 1'b1;
    bus.MEM_rd        = 5'd7; #2;
    n_checks++;
    if (bus.ID_Issue !== 1'b1) begin n_fail++; $display("FAIL b2b_release got %b want 1", bus.ID_Issue); end
    advance();
    idle(); #2;
    n_checks++;
    if (bus.Busy_Vec[7] !== 1'b0) begin n_fail++; $display("FAIL b2b_clear got %b want 0", bus.Busy_Vec[7]); end
    advance();
  endtask

  task automatic test_flush();
    int cnt0;
    drive_load(4); advance();
    cnt0 = m_cnt;
    drive_alu(4, 0, 9);
    bus.Flush = 1'b1; #2;
    n_checks++;
    if (bus.ID_Issue !== 1'b0) begin n_fail++; $display("FAIL flush_issue got %b want 0", bus.ID_Issue); end
    advance();
    idle(); #2;
    n_checks += 2;
    if (bus.Stall_Cnt !== 16'(cnt0)) begin n_fail++; $display("FAIL flush_cnt got %0d want %0d", bus.Stall_Cnt, cnt0); end
    if (bus.Busy_Vec !== 32'h10) begin n_fail++; $display("FAIL flush_busy got %h want 10", bus.Busy_Vec); end
    bus.MEM_Load_Done = 1'b1;
    bus.MEM_rd        = 5'd4;
    advance();
    idle();
    advance();
  endtask

  task automatic test_drain();
    int pulses;
    pulses = 0;
    drive_load(3); advance();
    drive_load(9); advance();
    idle();
    bus.Drain_Req     = 1'b1;
    bus.MEM_Load_Done = 1'b1;
    bus.MEM_rd        = 5'd3; #2;
    if (bus.Drain_Done) pulses++;
    advance();
    idle();
    bus.Drain_Req = 1'b1;
    bus.ID_Valid  = 1'b1; #2;
    n_checks += 2;
    if (bus.Stall !== 1'b1) begin n_fail++; $display("FAIL drain_c3_stall got %b want 1", bus.Stall); end
    if (bus.ID_Issue !== 1'b0) begin n_fail++; $display("FAIL drain_c3_issue got %b want 0", bus.ID_Issue); end
    if (bus.Drain_Done) pulses++;
    advance();
    bus.MEM_Load_Done = 1'b1;
    bus.MEM_rd        = 5'd9; #2;
    n_checks++;
    if (bus.Stall !== 1'b1) begin n_fail++; $display("FAIL drain_c4_stall got %b want 1", bus.Stall); end
    if (bus.Drain_Done) pulses++;
    advance();
    idle();
    bus.ID_Valid = 1'b1; #2;
    n_checks += 3;
    if (bus.Drain_Done !== 1'b1) begin n_fail++; $display("FAIL drain_done got %b want 1", bus.Drain_Done); end
    if (bus.Stall !== 1'b0) begin n_fail++; $display("FAIL drain_exit_stall got %b want 0", bus.Stall); end
    if (bus.ID_Issue !== 1'b1) begin n_fail++; $display("FAIL drain_exit_issue got %b want 1", bus.ID_Issue); end
    if (bus.Drain_Done) pulses++;
    for (int i = 0; i < 3; i++) begin
      advance(); #2;
      if (bus.Drain_Done) pulses++;
    end
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL drain_pulses got %0d want 1", pulses); end
    idle();
    advance();
  endtask

  task automatic test_reset_mid_stall();
    drive_load(5); advance();
    drive_load(9); advance();
    drive_alu(5, 9, 10); #2;
    n_checks += 2;
    if (bus.Busy_Vec !== 32'h0000_0220) begin n_fail++; $display("FAIL rst_pre_busy got %h want 220", bus.Busy_Vec); end
    if (bus.Stall !== 1'b1) begin n_fail++; $display("FAIL rst_pre_stall got %b want 1", bus.Stall); end
    advance();
    RST = 1'b1;
    advance();
    RST = 1'b0; #2;
    n_checks += 3;
    if (bus.Busy_Vec !== 32'h0) begin n_fail++; $display("FAIL rst_mid_busy got %h want 0", bus.Busy_Vec); end
    if (bus.Stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall got %b want 0", bus.Stall); end
    if (bus.Stall_Cnt !== 16'h0) begin n_fail++; $display("FAIL rst_mid_cnt got %h want 0", bus.Stall_Cnt); end
    idle();
    advance();
  endtask

  task automatic test_random();
    bit st, iss, haz, empty;
    for (int c = 0; c < 3000; c++) begin
      RST = ($urandom_range(0, 249) == 0);
      bus.ID_Valid      = ($urandom_range(0, 3) != 0);
      bus.ID_rs1        = 5'($urandom_range(0, 7));
      bus.ID_rs2        = 5'($urandom_range(0, 7));
      bus.ID_rs1_Used   = 1'($urandom_range(0, 1));
      bus.ID_rs2_Used   = 1'($urandom_range(0, 1));
      bus.ID_rd         = 5'($urandom_range(0, 7));
      bus.ID_Reg_Wr     = ($urandom_range(0, 3) != 0);
      bus.ID_Mem_Rd     = 1'($urandom_range(0, 1));
      bus.Flush         = ($urandom_range(0, 9) == 0);
      bus.MEM_Load_Done = ($urandom_range(0, 9) < 4);
      bus.MEM_rd        = 5'($urandom_range(0, 7));
      bus.Drain_Req     = m_draining ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 29) == 0);
      #2;
      model_comb(st, iss, haz, empty);
      n_checks += 5;
      if (bus.Stall !== st) begin n_fail++; $display("FAIL rnd_stall c%0d got %b want %b", c, bus.Stall, st); end
      if (bus.ID_Issue !== iss) begin n_fail++; $display("FAIL rnd_issue c%0d got %b want %b", c, bus.ID_Issue, iss); end
      if (bus.Busy_Vec !== m_busy_word()) begin n_fail++; $display("FAIL rnd_busy c%0d got %h want %h", c, bus.Busy_Vec, m_busy_word()); end
      if (bus.Stall_Cnt !== 16'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt c%0d got %0d want %0d", c, bus.Stall_Cnt, m_cnt); end
      if (bus.Drain_Done !== m_done) begin n_fail++; $display("FAIL rnd_done c%0d got %b want %b", c, bus.Drain_Done, m_done); end
      advance();
    end
    RST = 1'b0;
    idle();
    advance();
  endtask

  task automatic test_saturate();
    do_reset();
    drive_load(5); advance();
    drive_alu(5, 0, 6);
    for (int i = 0; i < 65540; i++) advance();
    #2;
    n_checks += 2;
    if (bus.Stall_Cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_cnt got %h want ffff", bus.Stall_Cnt); end
    if (bus.Stall_Cnt !== 16'(m_cnt)) begin n_fail++; $display("FAIL sat_model got %0d want %0d", bus.Stall_Cnt, m_cnt); end
    do_reset();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_draining = 1'b0;
    m_done     = 1'b0;
    m_cnt      = 0;
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    RST = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_x0();
    test_back_to_back();
    test_flush();
    test_drain();
    test_reset_mid_stall();
    test_random();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/load_use_scoreboard.md
# load_use_scoreboard

Register-busy scoreboard and stall controller for the RV32I 5-stage pipeline, sitting between ID and EX. It handles the producer side of operand delivery. It records every in-flight load destination from the cycle the load leaves ID until its data can be forwarded from MEM/WB. Dependent instructions are held in ID, with bubbles inserted into ID/EX, for exactly as long as the data is unavailable. It also provides a drain handshake that empties all outstanding loads before FENCE/ECALL.

## Interface
Parameters:
- WIDTH_SOURCE, 5, register index width
- CNT_WIDTH, 16, stall-cycle counter width

Ports:
- CLK  in  1  pipeline clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- ID_Valid  in  1  ID holds a valid instruction
- ID_rs1, ID_rs2  in  WIDTH_SOURCE  source indices of the ID instruction
- ID_rs1_Used, ID_rs2_Used  in  1  source is actually read
- ID_rd  in  WIDTH_SOURCE  destination of the ID instruction
- ID_Reg_Wr  in  1  ID instruction writes rd
- ID_Mem_Rd  in  1  ID instruction is a load
- Flush  in  1  branch/jump redirect; the ID instruction is killed this cycle
- MEM_Load_Done  in  1  a load completes its MEM stage this cycle
- MEM_rd  in  WIDTH_SOURCE  destination of the completing load
- Drain_Req  in  1  level request to empty the scoreboard
- ID_Issue  out  1  the ID instruction advances into EX this cycle
- Stall  out  1  hold PC and IF/ID; insert a NOP into ID/EX
- Drain_Done  out  1  one-cycle pulse when the drain completes
- Busy_Vec  out  2^WIDTH_SOURCE  registered busy bit per register
- Stall_Cnt  out  CNT_WIDTH  saturating count of hazard-stall cycles

## Operation
- Clear mask: one-hot(MEM_rd) when MEM_Load_Done, else 0. Effective busy = Busy_Vec & ~clear mask. This bypass is required because the completing load forwards from MEM/WB the next cycle.
- Hazard = ID_Valid & ((ID_rs1_Used & eff_busy[ID_rs1]) | (ID_rs2_Used & eff_busy[ID_rs2])). Index 0 is never busy.
- Stall = Hazard | (state==DRAIN).
- ID_Issue = ID_Valid & ~Stall & ~Flush.
- Set: on ID_Issue & ID_Mem_Rd & ID_Reg_Wr & (ID_rd!=0), set Busy_Vec[ID_rd].
- Set and clear of the same index in the same cycle: set wins, because a newer load owns the register.
- Non-load writers never set bits; the forwarding path covers them.
- Flush affects only ID. Issued loads stay tracked and clear normally.
- FSM states: RUN, STALL, DRAIN. Reset state is RUN.
  - RUN -> DRAIN when Drain_Req, with priority over hazard.
  - RUN -> STALL when Hazard.
  - STALL -> RUN when ~Hazard.
  - STALL -> DRAIN when Drain_Req.
  - DRAIN -> RUN when (eff_busy==0). Drain_Done is registered high for exactly the next cycle.
  - Drain_Req must be held until Drain_Done. If Drain_Req drops early in DRAIN, the FSM stays in DRAIN until empty.
- Stall_Cnt increments on each cycle with Hazard & ~Flush. It saturates at all-ones and never wraps. Drain cycles are not counted.
- Reset values: Busy_Vec=0, state RUN, Drain_Done=0, Stall_Cnt=0. Hence Stall=0 and ID_Issue=ID_Valid&~Flush.
- Reset asserted mid-stall or mid-drain: the next cycle is the full reset state and no Drain_Done pulse is produced.

## Timing
- Stall, Hazard and ID_Issue are combinational from registered state and same-cycle inputs. There is no extra cycle of latency.
- Busy_Vec updates one edge after the set or clear event.
- Load issued at cycle N, MEM_Load_Done at N+2 (memory ready): a dependent in ID at N+1 stalls for 1 cycle and issues at N+2.
- Each extra cycle the load spends in MEM adds one stall cycle.
- DRAIN with an empty scoreboard at entry: exit after 1 cycle in DRAIN; Drain_Done is high the following cycle.

## Test plan
- Load x5 issues at cycle 0; `add x6,x5,x1` in ID at cycle 1; MEM_Load_Done/MEM_rd=5 at cycle 2 -> Stall=1 at cycle 1 only, ID_Issue=1 at cycle 2, Busy_Vec[5] 1 during cycle 1 and 0 from cycle 3, Stall_Cnt=1.
- Load to x0 followed by a consumer of x0 -> Busy_Vec stays 0 and Stall is never asserted.
- Two loads to x7 back to back, with the first load completing in the same cycle the second issues -> Busy_Vec[7] remains 1; a consumer of x7 stalls until the second load completes.
- Dependent stalled in ID while Flush=1 -> ID_Issue=0; Stall_Cnt unchanged; Busy_Vec unchanged.
- Loads to x3 and x9 outstanding, Drain_Req=1 -> Stall=1 until both complete; Drain_Done pulses exactly once, one cycle after the last clear; the FSM returns to RUN.
- RST asserted during STALL with Busy_Vec=0x0000_0220 -> next cycle Busy_Vec=0, Stall=0, Stall_Cnt=0. Separately, force 2^16 hazard cycles -> Stall_Cnt holds 0xFFFF.
